exe_muldiv: RTL and testbench
=============================

# exe_muldiv

Iterative multiply/divide unit for the EXE stage of the 5-stage MIPS pipeline. It consumes the operand pair and the decoded mul/div control from the ID/EXE pipeline register and executes MULT, MULTU, DIV and DIVU over 33 cycles. Results go to the architectural HI/LO registers. It raises a stall toward the hazard unit so ID/EXE and earlier stages hold while an operation is in flight.

## Interface
Parameters:
- XLEN, 32, operand width; HI and LO are each XLEN bits.

Ports:
- clk  in  1  pipeline clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  launch request; valid only when op_i is a mul/div op.
- op_i  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a_i  in  XLEN  rs operand, taken from ID/EXE readData1.
- b_i  in  XLEN  rt operand, taken from ID/EXE readData2.
- flush  in  1  cancels any in-flight operation.
- busy  out  1  operation in flight.
- stall  out  1  hold request to the hazard unit: start OR busy (combinational).
- done  out  1  one-cycle pulse; HI/LO valid from this cycle.
- hi  out  XLEN  HI register.
- lo  out  XLEN  LO register.

## Operation
- FSM states: IDLE, CALC, FIX. Encoding is defined in the shared package.
- IDLE, start=1, flush=0:
  - Latch op_i.
  - For signed ops, latch |a_i| and |b_i| plus both sign bits.
  - Clear the 5-bit counter.
  - Go to CALC.
- CALC performs one iteration per cycle:
  - Multiply: shift-add, 64-bit accumulator.
  - Divide: restoring, 1 quotient bit per cycle.
  - After counter==31, go to FIX.
- FIX:
  - Signed mul: negate the 64-bit product if sa^sb.
  - Signed div: negate the quotient if sa^sb; negate the remainder if sa.
  - Write HI = high word / remainder, LO = low word / quotient.
  - Assert done on the next cycle. Return to IDLE.
- Divide by zero: runs full latency, no trap. HI = a_i, LO = all ones (same for signed and unsigned).
- Signed 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0. This falls out of the unsigned-magnitude path and needs no special case.
- start while busy: ignored.
- flush in any state: return to IDLE on the next edge. HI/LO are unchanged and done is not asserted.
- flush and start in the same cycle: flush wins; nothing is launched.
- flush in the FIX cycle: HI/LO are not written.
- Reset (rst=0), asynchronous, including mid-operation:
  - state = IDLE, counter = 0.
  - busy = 0, done = 0, hi = 0, lo = 0.
  - All datapath registers = 0.

## Timing
- start sampled at edge E0.
- busy = 1 from after E0 through E33: 32 CALC cycles plus 1 FIX cycle.
- HI/LO are written at E33. done = 1 and busy = 0 for exactly the cycle after E33.
- A new start is accepted in that same done cycle. Back-to-back throughput is one op per 34 cycles.
- stall is high in the start cycle and in every busy cycle. It is low in the done cycle unless start is asserted again.
- hi/lo are registered and hold their value between writes.

## Structure
- Shared package mips_pkg:
  - XLEN default.
  - Mul/div op encodings (MULT=2'b00, MULTU=2'b01, DIV=2'b10, DIVU=2'b11).
  - FSM state encoding.
- One sub-module: muldiv_step.
  - Combinational single-iteration datapath, one shift-add or restore step.
  - Selected by an is_div flag.
  - exe_muldiv owns the FSM, counter, sign-fix and HI/LO.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF: done at E0+34; HI = 0xFFFFFFFE, LO = 0x00000001. busy high for 33 cycles.
- MULT −3 × 7: HI = 0xFFFFFFFF, LO = 0xFFFFFFEB.
- DIV −7 / 2: LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIVU 100 / 0: HI = 100, LO = 0xFFFFFFFF.
- start DIVU 9/4, then flush asserted at cycle 10:
  - busy drops after the next edge; no done pulse.
  - HI/LO keep their prior values.
  - A fresh start then completes normally (LO = 2, HI = 1).
- rst pulled low mid-CALC, asynchronously between edges: busy, done, hi and lo go to 0 immediately. A second start during busy is ignored: one done, result of the first op.
- Back-to-back: start DIVU 20/3, then re-assert start with MULTU 5×6 in the done cycle. Second done arrives exactly 34 cycles later with LO = 30.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the EXE-stage multiply/divide unit.
//   DEFAULT_XLEN : default operand width (HI and LO are each this wide)
//   md_op_e      : mul/div opcode as decoded into ID/EXE
//   md_state_e   : iterative unit FSM states
//   md_is_signed : true for the signed opcodes (MULT, DIV)
package mips_pkg;

  localparam int DEFAULT_XLEN = 32;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10
  } md_state_e;

  // Signed ops are the even encodings; bit 1 selects divide.
  function automatic logic md_is_signed(input logic [1:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/exe_muldiv_step.sv
// muldiv_step: one combinational iteration of the multiply/divide datapath.
//   is_div : 1 = one restoring-division step, 0 = one shift-add multiply step
//   acc_i  : 2*XLEN accumulator {upper, lower}
//            multiply: {partial product, remaining multiplier bits}
//            divide  : {partial remainder, remaining dividend / quotient bits}
//   b_i    : multiplicand or divisor magnitude
//   acc_o  : accumulator after this iteration
module muldiv_step
  import mips_pkg::*;
#(
  parameter int XLEN = DEFAULT_XLEN
) (
  input  logic              is_div,
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   b_i,
  output logic [2*XLEN-1:0] acc_o
);

  logic [XLEN:0]   add_sum;    // upper word plus optional multiplicand, with carry
  logic [XLEN:0]   rem_shift;  // partial remainder after shifting in the next dividend bit
  logic [XLEN+1:0] sub_diff;   // trial subtraction, MSB is the borrow

  always_comb begin
    add_sum   = {1'b0, acc_i[2*XLEN-1:XLEN]} +
                (acc_i[0] ? {1'b0, b_i} : {(XLEN+1){1'b0}});
    rem_shift = acc_i[2*XLEN-1:XLEN-1];
    sub_diff  = {1'b0, rem_shift} - {2'b00, b_i};
    acc_o     = '0;

    if (!is_div) begin
      // Carry lands in the top bit; the consumed multiplier bit falls off the bottom.
      acc_o = {add_sum, acc_i[XLEN-1:1]};
    end else if (sub_diff[XLEN+1]) begin
      // Borrow: restore (keep the shifted remainder) and record a 0 quotient bit.
      acc_o = {rem_shift[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
    end else begin
      // The shifted remainder is below 2*divisor, so the difference fits in XLEN bits.
      acc_o = {sub_diff[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/exe_muldiv.sv
// exe_muldiv: iterative MULT/MULTU/DIV/DIVU unit for the EXE stage.
// Operates on magnitudes for XLEN cycles, then fixes signs in one extra cycle
// and writes the architectural HI/LO registers.
//   clk   : pipeline clock
//   rst   : asynchronous, active-low reset
//   start : launch request (ignored while busy or when flush is high)
//   op_i  : 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a_i   : rs operand, b_i : rt operand
//   flush : cancels any in-flight operation, HI/LO untouched
//   busy  : operation in flight (CALC or FIX)
//   stall : hold request to the hazard unit, start | busy
//   done  : one-cycle pulse in the cycle after HI/LO are written
//   hi/lo : HI and LO registers
module exe_muldiv
  import mips_pkg::*;
#(
  parameter int XLEN = DEFAULT_XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            flush,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int            CW      = $clog2(XLEN);
  localparam logic [CW-1:0] CNT_MAX = CW'(XLEN - 1);

  md_state_e         state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [1:0]        op_q, op_d;
  logic              sa_q, sa_d;
  logic              sb_q, sb_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic              done_q, done_d;

  logic              in_signed;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              op_signed_q;
  logic              is_div_q;
  logic              div_zero;
  logic              neg_result;
  logic [2*XLEN-1:0] step_acc;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  // Operand magnitudes; unsigned ops pass straight through. The most negative
  // value maps to itself, which is the correct unsigned magnitude.
  assign in_signed = md_is_signed(op_i);
  assign a_mag     = (in_signed && a_i[XLEN-1]) ? -a_i : a_i;
  assign b_mag     = (in_signed && b_i[XLEN-1]) ? -b_i : b_i;

  assign op_signed_q = md_is_signed(op_q);
  assign is_div_q    = op_q[1];
  assign div_zero    = (b_q == '0);
  assign neg_result  = op_signed_q && (sa_q ^ sb_q);

  muldiv_step #(
    .XLEN(XLEN)
  ) u_step (
    .is_div(is_div_q),
    .acc_i (acc_q),
    .b_i   (b_q),
    .acc_o (step_acc)
  );

  // Sign correction of the magnitude result. A zero divisor leaves the
  // all-ones quotient alone so signed and unsigned divide-by-zero agree;
  // the remainder still takes the dividend sign, which restores HI = a.
  always_comb begin
    prod_fix = acc_q;
    quo_fix  = acc_q[XLEN-1:0];
    rem_fix  = acc_q[2*XLEN-1:XLEN];
    if (neg_result) begin
      prod_fix = -acc_q;
    end
    if (neg_result && !div_zero) begin
      quo_fix = -acc_q[XLEN-1:0];
    end
    if (op_signed_q && sa_q) begin
      rem_fix = -acc_q[2*XLEN-1:XLEN];
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    acc_d   = acc_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;

    if (flush) begin
      // Flush beats everything, including a same-cycle start and the FIX write.
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            op_d    = op_i;
            sa_d    = in_signed & a_i[XLEN-1];
            sb_d    = in_signed & b_i[XLEN-1];
            acc_d   = {{XLEN{1'b0}}, a_mag};
            b_d     = b_mag;
            cnt_d   = '0;
            state_d = ST_CALC;
          end
        end
        ST_CALC: begin
          acc_d = step_acc;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_MAX) begin
            state_d = ST_FIX;
          end
        end
        ST_FIX: begin
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            hi_d = prod_fix[2*XLEN-1:XLEN];
            lo_d = prod_fix[XLEN-1:0];
          end
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      acc_q   <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy  = (state_q != ST_IDLE);
  assign stall = start | busy;
  assign done  = done_q;
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_exe_muldiv.sv
// Self-checking bench for exe_muldiv: expected HI/LO values are computed by a
// behavioural model at launch time, queued, and compared when done pulses.
module tb_exe_muldiv;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  op_i = 2'b00;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic        busy, stall, done;
  logic [31:0] hi, lo;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  exe_muldiv #(.XLEN(32)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .op_i (op_i),
    .a_i  (a_i),
    .b_i  (b_i),
    .flush(flush),
    .busy (busy),
    .stall(stall),
    .done (done),
    .hi   (hi),
    .lo   (lo)
  );

  // Behavioural reference: returns {HI, LO}.
  function automatic logic [63:0] model_md(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    longint p;
    int q, m;
    logic [63:0] r;
    r = '0;
    case (op)
      2'b00: begin
        p = longint'($signed(a)) * longint'($signed(b));
        r = p;
      end
      2'b01: r = {32'h0, a} * {32'h0, b};
      2'b10: begin
        if (b == 32'h0) r = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'h0, 32'h8000_0000};
        else begin
          q = $signed(a) / $signed(b);
          m = $signed(a) % $signed(b);
          r = {m, q};
        end
      end
      default: begin
        if (b == 32'h0) r = {a, 32'hFFFF_FFFF};
        else r = {a % b, a / b};
      end
    endcase
    return r;
  endfunction

  // Drive a start for one cycle from a negedge; returns at the negedge after E0.
  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit track, output logic stall_at_start);
    op_i  = op;
    a_i   = a;
    b_i   = b;
    start = 1'b1;
    if (track) exp_q.push_back(model_md(op, a, b));
    #1 stall_at_start = stall;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait (bounded) for done; cycles counts negedges after the one following E0.
  task automatic wait_done(input int budget, output bit timed_out, output int cycles,
                           output int busy_cycles);
    timed_out   = 1'b0;
    cycles      = 0;
    busy_cycles = 0;
    while (done !== 1'b1) begin
      if (busy === 1'b1) busy_cycles++;
      if (cycles >= budget) begin
        timed_out = 1'b1;
        break;
      end
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset();
    start = 1'b0;
    flush = 1'b0;
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({busy, done, stall} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_flags got busy/done/stall=%b required 000", {busy, done, stall});
    end
    tests_run++;
    if ({hi, lo} !== 64'h0) begin
      tests_failed++;
      $display("FAIL reset_hilo got %h_%h required 0_0", hi, lo);
    end
    rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release_busy got %b required 0", busy);
    end
  endtask

  task automatic test_latency();
    logic st;
    bit to;
    int cyc, bcyc;
    logic [63:0] e;
    launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, st);
    tests_run++;
    if (st !== 1'b1) begin
      tests_failed++;
      $display("FAIL stall_start_cycle got %b required 1", st);
    end
    wait_done(60, to, cyc, bcyc);
    tests_run++;
    if (to || cyc != 33) begin
      tests_failed++;
      $display("FAIL latency_done got cycles=%0d timeout=%0d required 33", cyc, to);
    end
    tests_run++;
    if (bcyc != 33) begin
      tests_failed++;
      $display("FAIL latency_busy got %0d busy cycles required 33", bcyc);
    end
    tests_run++;
    if ({busy, stall} !== 2'b00) begin
      tests_failed++;
      $display("FAIL done_cycle_busy_stall got %b required 00", {busy, stall});
    end
    if (exp_q.size() == 0) e = 'x;
    else e = exp_q.pop_front();
    $display("[TB] MULTU ffffffff*ffffffff -> hi=%h lo=%h", hi, lo);
    tests_run++;
    if ({hi, lo} !== e) begin
      tests_failed++;
      $display("FAIL multu_max got %h_%h required %h_%h", hi, lo, e[63:32], e[31:0]);
    end
    @(negedge clk);
    tests_run++;
    if (done !== 1'b0) begin
      tests_failed++;
      $display("FAIL done_pulse_width got %b required 0 one cycle later", done);
    end
  endtask

  task automatic test_arith();
    logic [1:0]  t_op[12] = '{2'b00, 2'b10, 2'b11, 2'b10, 2'b10, 2'b00,
                              2'b01, 2'b10, 2'b11, 2'b00, 2'b10, 2'b11};
    logic [31:0] t_a[12]  = '{32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'd100, 32'hFFFF_FFFB,
                              32'h8000_0000, 32'h8000_0000, 32'h1234_5678, 32'd100,
                              32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0};
    logic [31:0] t_b[12]  = '{32'd7, 32'd2, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h8000_0000,
                              32'h9ABC_DEF0, 32'hFFFF_FFF9, 32'd3, 32'h0, 32'h0, 32'h0};
    logic st;
    bit to;
    int cyc, bcyc;
    logic [63:0] e;
    // Last three entries take random operands.
    for (int i = 9; i < 12; i++) begin
      t_a[i] = $urandom;
      t_b[i] = $urandom_range(1, 32'h7FFF_FFFF);
      if (i == 10) t_b[i] = -t_b[i];
    end
    for (int i = 0; i < 12; i++) begin
      launch(t_op[i], t_a[i], t_b[i], 1'b1, st);
      wait_done(60, to, cyc, bcyc);
      if (exp_q.size() == 0) e = 'x;
      else e = exp_q.pop_front();
      $display("[TB] op=%0d a=%h b=%h -> hi=%h lo=%h", t_op[i], t_a[i], t_b[i], hi, lo);
      tests_run++;
      if (to || {hi, lo} !== e) begin
        tests_failed++;
        $display("FAIL arith_%0d got %h_%h timeout=%0d required %h_%h", i, hi, lo, to,
                 e[63:32], e[31:0]);
      end
    end
  endtask

  task automatic test_flush();
    logic st;
    bit to;
    int cyc, bcyc, seen;
    logic [31:0] hi_prev, lo_prev;
    logic [63:0] e;
    hi_prev = hi;
    lo_prev = lo;
    // Flush in mid-CALC.
    launch(2'b11, 32'd9, 32'd4, 1'b0, st);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_calc_busy got %b required 0", busy);
    end
    // Flush in the FIX cycle (32 negedges after E0).
    launch(2'b01, 32'd3, 32'd3, 1'b0, st);
    repeat (32) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    // Flush together with start launches nothing.
    op_i  = 2'b01;
    a_i   = 32'd11;
    b_i   = 32'd11;
    start = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_with_start_busy got %b required 0", busy);
    end
    seen = 0;
    repeat (40) begin
      if (done === 1'b1) seen++;
      @(negedge clk);
    end
    tests_run++;
    if (seen != 0) begin
      tests_failed++;
      $display("FAIL flush_no_done got %0d done pulses required 0", seen);
    end
    tests_run++;
    if (hi !== hi_prev || lo !== lo_prev) begin
      tests_failed++;
      $display("FAIL flush_hilo_kept got %h_%h required %h_%h", hi, lo, hi_prev, lo_prev);
    end
    launch(2'b11, 32'd9, 32'd4, 1'b1, st);
    wait_done(60, to, cyc, bcyc);
    if (exp_q.size() == 0) e = 'x;
    else e = exp_q.pop_front();
    $display("[TB] DIVU 9/4 after flush -> hi=%h lo=%h", hi, lo);
    tests_run++;
    if (to || {hi, lo} !== e) begin
      tests_failed++;
      $display("FAIL flush_then_divu got %h_%h required %h_%h", hi, lo, e[63:32], e[31:0]);
    end
  endtask

  task automatic test_async_reset();
    logic st;
    bit to;
    int cyc, bcyc, seen;
    logic [63:0] e;
    launch(2'b01, 32'd7, 32'd9, 1'b0, st);
    repeat (10) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    tests_run++;
    if ({busy, done} !== 2'b00 || {hi, lo} !== 64'h0) begin
      tests_failed++;
      $display("FAIL async_reset got busy=%b done=%b hi=%h lo=%h required all 0",
               busy, done, hi, lo);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    // A second start while busy is ignored.
    launch(2'b11, 32'd20, 32'd6, 1'b1, st);
    repeat (5) @(negedge clk);
    op_i  = 2'b01;
    a_i   = 32'd5;
    b_i   = 32'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(60, to, cyc, bcyc);
    if (exp_q.size() == 0) e = 'x;
    else e = exp_q.pop_front();
    $display("[TB] DIVU 20/6 with ignored start -> hi=%h lo=%h", hi, lo);
    tests_run++;
    if (to || {hi, lo} !== e) begin
      tests_failed++;
      $display("FAIL busy_start_ignored got %h_%h required %h_%h", hi, lo, e[63:32], e[31:0]);
    end
    @(negedge clk);
    seen = 0;
    repeat (40) begin
      if (done === 1'b1) seen++;
      @(negedge clk);
    end
    tests_run++;
    if (seen != 0) begin
      tests_failed++;
      $display("FAIL busy_start_single_done got %0d extra done pulses required 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    logic st;
    bit to;
    int cyc, bcyc;
    logic [63:0] e;
    launch(2'b11, 32'd20, 32'd3, 1'b1, st);
    wait_done(60, to, cyc, bcyc);
    if (exp_q.size() == 0) e = 'x;
    else e = exp_q.pop_front();
    $display("[TB] DIVU 20/3 -> hi=%h lo=%h", hi, lo);
    tests_run++;
    if (to || {hi, lo} !== e) begin
      tests_failed++;
      $display("FAIL b2b_first got %h_%h required %h_%h", hi, lo, e[63:32], e[31:0]);
    end
    // Relaunch in the done cycle.
    launch(2'b01, 32'd5, 32'd6, 1'b1, st);
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_accept got busy=%b required 1", busy);
    end
    wait_done(60, to, cyc, bcyc);
    tests_run++;
    if (to || cyc + 1 != 34) begin
      tests_failed++;
      $display("FAIL b2b_spacing got %0d cycles timeout=%0d required 34", cyc + 1, to);
    end
    if (exp_q.size() == 0) e = 'x;
    else e = exp_q.pop_front();
    $display("[TB] MULTU 5*6 back-to-back -> hi=%h lo=%h", hi, lo);
    tests_run++;
    if ({hi, lo} !== e) begin
      tests_failed++;
      $display("FAIL b2b_second got %h_%h required %h_%h", hi, lo, e[63:32], e[31:0]);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_arith();
    test_flush();
    test_async_reset();
    test_back_to_back();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain got %0d entries left required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
